// File: rtl/rom_copy_if.sv
// Bus bundle for rom_copy_engine: copy request, status, ROM macro port
// and destination write port. The master modport is the engine side.
// With ROM_COPY_CHECKSUM_EN defined the bundle also carries checksum.
interface rom_copy_if #(
   parameter int ROM_AW = 11,
   parameter int DATA_W = 32,
   parameter int DST_AW = 32
);
   logic              start;
   logic [ROM_AW-1:0] src_addr;
   logic [DST_AW-1:0] dst_addr;
   logic [ROM_AW:0]   word_count;
   logic              busy;
   logic              done;
   logic              rom_me;
   logic              rom_oe;
   logic [ROM_AW-1:0] rom_address;
   logic [DATA_W-1:0] rom_q;
   logic              wr_valid;
   logic              wr_ready;
   logic [DST_AW-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
`ifdef ROM_COPY_CHECKSUM_EN
   logic [DATA_W-1:0] checksum;

   modport master (
      input  start, src_addr, dst_addr, word_count, rom_q, wr_ready,
      output busy, done, rom_me, rom_oe, rom_address, wr_valid, wr_addr, wr_data,
             checksum
   );
   modport slave (
      output start, src_addr, dst_addr, word_count, rom_q, wr_ready,
      input  busy, done, rom_me, rom_oe, rom_address, wr_valid, wr_addr, wr_data,
             checksum
   );
`else
   modport master (
      input  start, src_addr, dst_addr, word_count, rom_q, wr_ready,
      output busy, done, rom_me, rom_oe, rom_address, wr_valid, wr_addr, wr_data
   );
   modport slave (
      output start, src_addr, dst_addr, word_count, rom_q, wr_ready,
      input  busy, done, rom_me, rom_oe, rom_address, wr_valid, wr_addr, wr_data
   );
`endif
endinterface

// File: rtl/rom_copy_engine.sv
// rom_copy_engine: copies word_count words from a synchronous ROM macro
// (one-cycle read latency) to a valid/ready write port, one word per
// FETCH -> LATCH -> WRITE pass. Optional feature macro:
// ROM_COPY_CHECKSUM_EN adds a running modulo-2^DATA_W sum of written words.
//
// Write handshake: wr_valid rises in WRITE and stays high with wr_addr and
// wr_data held constant until a rising edge sees wr_valid && wr_ready; that
// edge is the transfer. Only reset may drop wr_valid before the transfer.
module rom_copy_engine #(
   parameter int ROM_AW = 11,
   parameter int DATA_W = 32,
   parameter int DST_AW = 32
) (
   input  logic        clock,
   input  logic        reset_n,
   rom_copy_if.master  bus,
   output logic [2:0]  dbg_state_o
);

   localparam int CNT_W = ROM_AW + 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_LATCH = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [ROM_AW-1:0] src_q, src_d;
   logic [DST_AW-1:0] dst_q, dst_d;
   logic [CNT_W-1:0]  rem_q, rem_d;
   logic [DATA_W-1:0] data_q, data_d;
`ifdef ROM_COPY_CHECKSUM_EN
   logic [DATA_W-1:0] checksum_q, checksum_d;
`endif

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         src_q      <= '0;
         dst_q      <= '0;
         rem_q      <= '0;
         data_q     <= '0;
`ifdef ROM_COPY_CHECKSUM_EN
         checksum_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         src_q      <= src_d;
         dst_q      <= dst_d;
         rem_q      <= rem_d;
         data_q     <= data_d;
`ifdef ROM_COPY_CHECKSUM_EN
         checksum_q <= checksum_d;
`endif
      end
   end

   // Next-state and datapath updates; request inputs are only looked at in IDLE.
   always_comb begin
      state_d    = state_q;
      src_d      = src_q;
      dst_d      = dst_q;
      rem_d      = rem_q;
      data_d     = data_q;
`ifdef ROM_COPY_CHECKSUM_EN
      checksum_d = checksum_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               src_d = bus.src_addr;
               dst_d = bus.dst_addr;
               rem_d = bus.word_count;
`ifdef ROM_COPY_CHECKSUM_EN
               checksum_d = '0;
`endif
               // A zero-length request goes straight to DONE without touching the ROM.
               state_d = (bus.word_count != '0) ? S_FETCH : S_DONE;
            end
         end
         S_FETCH: state_d = S_LATCH;
         S_LATCH: begin
            data_d  = bus.rom_q;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            if (bus.wr_ready) begin
               // Pointers wrap silently at their natural widths.
               src_d = src_q + ROM_AW'(1);
               dst_d = dst_q + DST_AW'(4);
               rem_d = rem_q - CNT_W'(1);
`ifdef ROM_COPY_CHECKSUM_EN
               checksum_d = checksum_q + data_q;
`endif
               state_d = (rem_q == CNT_W'(1)) ? S_DONE : S_FETCH;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from state and registers only, so all reset to zero.
   always_comb begin
      bus.busy        = (state_q == S_FETCH) || (state_q == S_LATCH) || (state_q == S_WRITE);
      bus.done        = (state_q == S_DONE);
      bus.rom_me      = (state_q == S_FETCH);
      bus.rom_oe      = bus.busy;
      bus.rom_address = src_q;
      bus.wr_valid    = (state_q == S_WRITE);
      bus.wr_addr     = dst_q;
      bus.wr_data     = data_q;
`ifdef ROM_COPY_CHECKSUM_EN
      bus.checksum    = checksum_q;
`endif
      dbg_state_o     = state_q;
   end

endmodule

// File: tb/tb_rom_copy_engine.sv
// Self-checking bench for rom_copy_engine. A ROM array plus a per-job model
// (expected write list, expected ROM addresses, cycle-level timing from the
// FETCH/LATCH/WRITE latency rules) is checked every cycle on the falling edge.
module tb_rom_copy_engine;

   localparam int ROM_AW = 11;
   localparam int DATA_W = 32;
   localparam int DST_AW = 32;
   localparam int ROM_WORDS = 1 << ROM_AW;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   rom_copy_if #(.ROM_AW(ROM_AW), .DATA_W(DATA_W), .DST_AW(DST_AW)) bus ();
   logic [2:0] dbg_state;

   rom_copy_engine #(.ROM_AW(ROM_AW), .DATA_W(DATA_W), .DST_AW(DST_AW)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   // Synchronous ROM macro: data appears one cycle after rom_me.
   logic [DATA_W-1:0] rom_mem [0:ROM_WORDS-1];
   always @(posedge clock) begin
      if (bus.rom_me) bus.rom_q <= rom_mem[bus.rom_address];
   end

   // ---------------- scoreboard ----------------
   logic [DST_AW+DATA_W-1:0] exp_q[$];
   logic [ROM_AW-1:0]        exp_rom_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check_eq({tag, " busy"},     64'(bus.busy),        64'(0));
      check_eq({tag, " done"},     64'(bus.done),        64'(0));
      check_eq({tag, " rom_me"},   64'(bus.rom_me),      64'(0));
      check_eq({tag, " rom_oe"},   64'(bus.rom_oe),      64'(0));
      check_eq({tag, " rom_addr"}, 64'(bus.rom_address), 64'(0));
      check_eq({tag, " wr_valid"}, 64'(bus.wr_valid),    64'(0));
      check_eq({tag, " wr_addr"},  64'(bus.wr_addr),     64'(0));
      check_eq({tag, " wr_data"},  64'(bus.wr_data),     64'(0));
`ifdef ROM_COPY_CHECKSUM_EN
      check_eq({tag, " checksum"}, 64'(bus.checksum),    64'(0));
`endif
   endtask

   // ---------------- driver + per-cycle model ----------------
   // ready_mode: 0 = always ready, 1 = random, 2 = first word stalled 5 cycles.
   // noisy: toggle start and scramble request inputs while the copy runs.
   // abort_at: >= 0 asserts reset during WRITE of word abort_at (0-based).
   task automatic run_copy(input logic [ROM_AW-1:0] src, input logic [DST_AW-1:0] dst,
                           input int cnt, input int ready_mode, input bit noisy,
                           input int abort_at);
      int k, done_k, next_fetch_k, valid_from, words_left, hs, stall, budget;
      bit pending, e_me, e_valid, e_done, e_busy, ready, finished;
      logic [DATA_W-1:0] sum;
      logic [ROM_AW-1:0] a;

      exp_q.delete();
      exp_rom_q.delete();
      sum = '0;
      for (int i = 0; i < cnt; i++) begin
         a = src + ROM_AW'(i);
         exp_rom_q.push_back(a);
         exp_q.push_back({dst + DST_AW'(4 * i), rom_mem[a]});
         sum = sum + rom_mem[a];
      end

      @(negedge clock);
      bus.start      = 1'b1;
      bus.src_addr   = src;
      bus.dst_addr   = dst;
      bus.word_count = (ROM_AW + 1)'(cnt);
      bus.wr_ready   = 1'b0;

      k = 0;
      done_k = (cnt == 0) ? 1 : -1;
      next_fetch_k = 1;
      valid_from = 0;
      words_left = cnt;
      pending = 1'b0;
      hs = 0;
      stall = 0;
      budget = 10 * cnt + 50;
      finished = 1'b0;

      while (!finished) begin
         @(negedge clock);
         k++;
         bus.start      = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.src_addr   = ROM_AW'($urandom_range(0, ROM_WORDS - 1));
         bus.dst_addr   = DST_AW'($urandom);
         bus.word_count = (ROM_AW + 1)'($urandom_range(0, ROM_WORDS));

         e_me = (words_left > 0) && !pending && (k == next_fetch_k);
         if (e_me) begin
            pending = 1'b1;
            valid_from = k + 2;
         end
         e_valid = pending && (k >= valid_from);
         e_done  = (k == done_k);
         e_busy  = pending || (words_left > 0);

         case (ready_mode)
            0: ready = 1'b1;
            1: ready = 1'($urandom_range(0, 1));
            default: begin
               ready = 1'b1;
               if (e_valid && hs == 0) begin
                  ready = (stall >= 5);
                  stall++;
               end
            end
         endcase

         check_eq("busy",     64'(bus.busy),     64'(e_busy));
         check_eq("done",     64'(bus.done),     64'(e_done));
         check_eq("rom_me",   64'(bus.rom_me),   64'(e_me));
         check_eq("rom_oe",   64'(bus.rom_oe),   64'(e_busy));
         check_eq("wr_valid", 64'(bus.wr_valid), 64'(e_valid));
         if (e_me && exp_rom_q.size() > 0) begin
            check_eq("rom_address", 64'(bus.rom_address), 64'(exp_rom_q[0]));
            void'(exp_rom_q.pop_front());
         end
         if (e_valid && exp_q.size() > 0)
            check_eq("wr_addr_data", 64'({bus.wr_addr, bus.wr_data}), 64'(exp_q[0]));

         if (abort_at >= 0 && hs == abort_at && e_valid) begin
            reset_n = 1'b0;
            bus.start = 1'b0;
            bus.wr_ready = 1'b0;
            @(negedge clock);
            check_reset_values("abort");
            reset_n = 1'b1;
            return;
         end

         bus.wr_ready = ready;
         if (e_valid && ready) begin
            void'(exp_q.pop_front());
            hs++;
            words_left--;
            pending = 1'b0;
            next_fetch_k = k + 1;
            if (words_left == 0) done_k = k + 1;
         end

         if (e_done) begin
            check_eq("handshakes", 64'(hs), 64'(cnt));
`ifdef ROM_COPY_CHECKSUM_EN
            check_eq("checksum", 64'(bus.checksum), 64'(sum));
`endif
            finished = 1'b1;
         end else if (k > budget) begin
            check_eq("timeout", 64'(k), 64'(budget));
            finished = 1'b1;
         end
      end

      // One cycle later the engine is back in IDLE and the result is held.
      @(negedge clock);
      bus.start = 1'b0;
      bus.wr_ready = 1'b0;
      check_eq("idle_busy", 64'(bus.busy),   64'(0));
      check_eq("idle_done", 64'(bus.done),   64'(0));
      check_eq("idle_me",   64'(bus.rom_me), 64'(0));
`ifdef ROM_COPY_CHECKSUM_EN
      check_eq("checksum_hold", 64'(bus.checksum), 64'(sum));
`endif
   endtask

   // ---------------- main sequence + report ----------------
   initial begin
      for (int i = 0; i < ROM_WORDS; i++) rom_mem[i] = DATA_W'($urandom);
      bus.start = 1'b0;
      bus.src_addr = '0;
      bus.dst_addr = '0;
      bus.word_count = '0;
      bus.wr_ready = 1'b0;
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      check_reset_values("reset");
      reset_n = 1'b1;

      run_copy(11'd0, 32'h8000_0000, 4, 0, 1'b0, -1);    // basic four-word copy
      run_copy(11'd5, 32'h0000_0100, 0, 0, 1'b0, -1);    // zero-length request
      run_copy(11'd2046, 32'h0000_0000, 3, 1, 1'b0, -1); // ROM pointer wrap
      run_copy(11'd10, 32'h0000_1000, 3, 2, 1'b0, -1);   // write stall on word 1
      run_copy(11'd20, 32'h0000_2000, 5, 1, 1'b1, -1);   // start pulses while busy
      run_copy(11'd100, 32'h0000_3000, 4, 0, 1'b0, 1);   // reset in WRITE of word 2
      run_copy(11'd100, 32'h0000_3000, 4, 0, 1'b0, -1);  // full copy after reset

      for (int j = 0; j < 15; j++)
         run_copy(ROM_AW'($urandom_range(0, ROM_WORDS - 1)), DST_AW'($urandom),
                  $urandom_range(0, 40), $urandom_range(0, 2),
                  1'($urandom_range(0, 1)), -1);

      run_copy(ROM_AW'($urandom_range(0, ROM_WORDS - 1)), 32'hFFFF_FF00,
               ROM_WORDS, 0, 1'b1, -1);                  // full ROM, dst wrap

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rom_copy_engine.md
ROM_COPY_ENGINE -- requirements
Module: rom_copy_engine

Interface
REQ-001 SHALL provide parameter ROM_AW, default 11, ROM word-address width (2048 words).
REQ-002 SHALL provide parameter DATA_W, default 32, ROM and write-port data width.
REQ-003 SHALL provide parameter DST_AW, default 32, destination byte-address width.
REQ-004 clock  input  1  sole clock; all state updates on rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 start  input  1  copy request; sampled only in IDLE.
REQ-007 src_addr  input  ROM_AW  first ROM word index.
REQ-008 dst_addr  input  DST_AW  first destination byte address.
REQ-009 word_count  input  ROM_AW+1  words to copy, 0..2048.
REQ-010 busy  output  1  high in FETCH, LATCH, WRITE.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 rom_me  output  1  ROM read enable, drives ROM macro me.
REQ-013 rom_oe  output  1  ROM output enable, drives ROM macro oe.
REQ-014 rom_address  output  ROM_AW  ROM word address.
REQ-015 rom_q  input  DATA_W  ROM read data, valid one cycle after rom_me.
REQ-016 wr_valid / wr_ready  output / input  1 / 1  destination write handshake.
REQ-017 wr_addr / wr_data  output / output  DST_AW / DATA_W  write address and data.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, LATCH, WRITE, DONE.
REQ-019 IDLE: start=1 SHALL latch src/dst addresses and count; count!=0 -> FETCH, count==0 -> DONE (no ROM read, no write).
REQ-020 FETCH: rom_me=1, rom_address=current src pointer, for exactly one cycle; -> LATCH.
REQ-021 LATCH: rom_q SHALL be captured into wr_data register; -> WRITE.
REQ-022 WRITE: wr_valid=1; wr_addr/wr_data SHALL stay stable until wr_valid&&wr_ready.
REQ-023 On handshake: src pointer +1 modulo 2^ROM_AW, dst pointer +4 modulo 2^DST_AW, remaining -1; remaining becomes 0 -> DONE, else -> FETCH.
REQ-024 DONE: done=1 for one cycle, busy=0; -> IDLE.
REQ-025 rom_oe SHALL be 1 in FETCH, LATCH, WRITE, else 0; rom_me 0 outside FETCH.
REQ-026 Latency: start accepted at edge N -> rom_me at N+1, wr_valid at N+3; with wr_ready held 1, one word per 3 cycles; done in cycle after last handshake.
REQ-027 start while busy or in DONE SHALL be ignored; input changes after acceptance SHALL not affect the copy.
REQ-028 src wrap-around SHALL occur silently (e.g. src 2047 -> 0); no error output.

Reset
REQ-029 reset_n=0 at a rising edge SHALL force IDLE from any state, including mid-WRITE (valid-hold rule waived).
REQ-030 Reset values: busy=0, done=0, rom_me=0, rom_oe=0, rom_address=0, wr_valid=0, wr_addr=0, wr_data=0, internal pointers and count=0.

Configuration
REQ-031 Macro ROM_COPY_CHECKSUM_EN defined: output checksum (DATA_W) SHALL be cleared on start acceptance, add wr_data modulo 2^DATA_W at each handshake, hold after done until next start, reset 0.
REQ-032 Macro ROM_COPY_CHECKSUM_EN undefined: checksum port and logic SHALL be absent; all other behaviour identical.

Verification
REQ-033 src=0, dst=0x80000000, count=4, wr_ready=1, ROM[0..3]=A,B,C,D -> writes (0x80000000,A),(..04,B),(..08,C),(..0C,D), done 13 cycles after start edge, checksum=A+B+C+D.
REQ-034 count=0 -> no rom_me, no wr_valid, done pulse one cycle after start, checksum=0.
REQ-035 src=2046, count=3 -> rom_address 2046, 2047, 0.
REQ-036 wr_ready low 5 cycles in WRITE of word 1 -> wr_valid, wr_addr, wr_data stable throughout; no rom_me during stall.
REQ-037 reset_n=0 in WRITE of word 2 of 4 -> next cycle all outputs at reset values, no done; new start performs full copy.
REQ-038 start pulsed while busy -> ignored; running copy completes with original parameters.
